// File: rtl/shift_unit_if.sv
// Request/response bundle for shift_unit: the requester drives start/mode/shamt/operand
// and receives busy/done/result/err.
interface shift_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) ();
  logic               start;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   operand;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               err;

  modport master (output start, mode, shamt, operand, input busy, done, result, err);
  modport slave  (input start, mode, shamt, operand, output busy, done, result, err);
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROTR, at most STEP bit positions per clock.
// Define SHIFT_UNIT_ROTATE_EN to build ROTR; otherwise mode 11 passes operand through with err=1.
module shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input logic        clk,
  input logic        rst_n,
  shift_unit_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_e;
  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROTR = 2'b11} op_e;

  // One extra bit so STEP == WIDTH is representable in the comparison.
  localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W + 1)'(STEP);

  state_e             state, state_next;
  op_e                op, op_next;
  logic [WIDTH-1:0]   work, work_next;
  logic [WIDTH-1:0]   result, result_next;
  logic [WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0] remaining, remaining_next;
  logic [SHAMT_W-1:0] amt;
  logic               done, done_next;
  logic               err, err_next;
  logic               illegal;
`ifdef SHIFT_UNIT_ROTATE_EN
  logic [2*WIDTH-1:0] rot;
`endif

  // Per-edge step: min(STEP, remaining), then apply the latched operation.
  always_comb begin
    if ({1'b0, remaining} > STEP_W) amt = STEP_W[SHAMT_W-1:0];
    else                            amt = remaining;
    shifted = work;
`ifdef SHIFT_UNIT_ROTATE_EN
    rot     = {work, work} >> amt;
    illegal = 1'b0;
`else
    illegal = (op == OP_ROTR);
`endif
    case (op)
      OP_SLL:  shifted = work << amt;
      OP_SRL:  shifted = work >> amt;
      OP_SRA:  shifted = $signed(work) >>> amt;
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROTR: shifted = rot[WIDTH-1:0];
`endif
      default: shifted = work;
    endcase
  end

  always_comb begin
    state_next     = state;
    op_next        = op;
    work_next      = work;
    remaining_next = remaining;
    result_next    = result;
    done_next      = 1'b0;
    err_next       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          op_next    = op_e'(bus.mode);
          work_next  = bus.operand;
`ifdef SHIFT_UNIT_ROTATE_EN
          remaining_next = bus.shamt;
`else
          // Unsupported rotate still spends exactly one SHIFT edge, unchanged.
          remaining_next = (bus.mode == 2'b11) ? '0 : bus.shamt;
`endif
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        work_next      = shifted;
        remaining_next = remaining - amt;
        if (remaining == amt) begin
          state_next  = IDLE;
          result_next = shifted;
          done_next   = 1'b1;
          err_next    = illegal;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= OP_SLL;
      work      <= '0;
      remaining <= '0;
      result    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      op        <= op_next;
      work      <= work_next;
      remaining <= remaining_next;
      result    <= result_next;
      done      <= done_next;
      err       <= err_next;
    end
  end

  assign bus.busy   = (state == SHIFT);
  assign bus.done   = done;
  assign bus.result = result;
  assign bus.err    = err;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit (WIDTH=32, SHAMT_W=5, STEP=4); inputs driven and outputs
// sampled on the falling edge. Honours SHIFT_UNIT_ROTATE_EN for the rotate expectations.
`define CHK(tag, obs, exp) \
  checks++; \
  assert ((obs) === (exp)) else begin \
    errors++; \
    $error("FAIL %s observed=%h expected=%h", tag, (obs), (exp)); \
  end

module tb_shift_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   n;
  logic seen;

  shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Present a request for one edge, then scramble the inputs.
  task automatic go(input logic [1:0] m, input logic [4:0] s, input logic [31:0] op);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.shamt = s; bus.operand = op;
    @(negedge clk);
    bus.start = 1'b0; bus.mode = ~m; bus.shamt = ~s; bus.operand = ~op;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (bus.done !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $error("FAIL wait_done expired after %0d cycles without done", cnt);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 2'b00; bus.shamt = '0; bus.operand = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    `CHK("rst_busy", bus.busy, 1'b0)
    `CHK("rst_done", bus.done, 1'b0)
    `CHK("rst_result", bus.result, 32'h0)
    `CHK("rst_err", bus.err, 1'b0)

    // Start presented together with reset release: accepted at the first edge.
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b1; bus.mode = 2'b00; bus.shamt = 5'd31; bus.operand = 32'h0000_0001;
    @(negedge clk);
    bus.start = 1'b0; bus.operand = 32'hFFFF_FFFF;
    `CHK("first_accept_busy", bus.busy, 1'b1)
    wait_done(n);
    `CHK("sll31_latency", n, 8)
    `CHK("sll31_result", bus.result, 32'h8000_0000)
    `CHK("sll31_err", bus.err, 1'b0)
    `CHK("sll31_busy_at_done", bus.busy, 1'b0)
    @(negedge clk);
    `CHK("done_one_cycle", bus.done, 1'b0)
    `CHK("result_hold", bus.result, 32'h8000_0000)

    go(2'b10, 5'd4, 32'h8000_0000);
    wait_done(n);
    `CHK("sra4_latency", n, 1)
    `CHK("sra4_result", bus.result, 32'hF800_0000)

    go(2'b01, 5'd4, 32'h8000_0000);
    wait_done(n);
    `CHK("srl4_result", bus.result, 32'h0800_0000)

    go(2'b01, 5'd0, 32'h1234_5678);
    wait_done(n);
    `CHK("shamt0_latency", n, 1)
    `CHK("shamt0_result", bus.result, 32'h1234_5678)
    `CHK("shamt0_err", bus.err, 1'b0)

    go(2'b00, 5'd5, 32'h0000_0001);
    wait_done(n);
    `CHK("sll5_latency", n, 2)
    `CHK("sll5_result", bus.result, 32'h0000_0020)

    go(2'b10, 5'd31, 32'h8000_0000);
    wait_done(n);
    `CHK("sra31_latency", n, 8)
    `CHK("sra31_result", bus.result, 32'hFFFF_FFFF)

    // Start while busy is ignored; start held in the done cycle is taken immediately.
    go(2'b00, 5'd31, 32'h0000_0001);
    bus.start = 1'b1; bus.mode = 2'b01; bus.shamt = 5'd1; bus.operand = 32'h0000_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    `CHK("ignored_latency", n, 7)
    `CHK("ignored_result", bus.result, 32'h8000_0000)
    bus.start = 1'b1; bus.mode = 2'b01; bus.shamt = 5'd4; bus.operand = 32'h0000_00F0;
    @(negedge clk);
    bus.start = 1'b0;
    `CHK("b2b_busy", bus.busy, 1'b1)
    wait_done(n);
    `CHK("b2b_latency", n, 1)
    `CHK("b2b_result", bus.result, 32'h0000_000F)

    // Asynchronous reset in the middle of an 8-edge operation.
    go(2'b00, 5'd31, 32'h0000_0001);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    `CHK("midrst_busy", bus.busy, 1'b0)
    `CHK("midrst_result", bus.result, 32'h0)
    `CHK("midrst_done", bus.done, 1'b0)
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | bus.done;
    end
    `CHK("midrst_no_done", seen, 1'b0)
    go(2'b01, 5'd8, 32'h1234_5678);
    wait_done(n);
    `CHK("postrst_latency", n, 2)
    `CHK("postrst_result", bus.result, 32'h0012_3456)

    go(2'b11, 5'd4, 32'h0000_00F1);
    wait_done(n);
    `CHK("rotr_latency", n, 1)
`ifdef SHIFT_UNIT_ROTATE_EN
    `CHK("rotr_result", bus.result, 32'h1000_000F)
    `CHK("rotr_err", bus.err, 1'b0)
`else
    `CHK("rotr_result", bus.result, 32'h0000_00F1)
    `CHK("rotr_err", bus.err, 1'b1)
`endif
    @(negedge clk);
    `CHK("err_clears", bus.err, 1'b0)

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
